mult_share_arbiter: RTL and testbench

//  Shares one pipelined 33x33 multiplier (simple_mult) between two requesters: port 0 = execute stage (MUL/IMUL/AAD),

---
 rtl/mult_share_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined 33x33 multiplier between two requesters.
// Operands are extended at issue; a tag pipeline routes each product back to its owner.
module mult_share_arbiter #(
    parameter int LATENCY       = 2,
    parameter bit RR_RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_signed,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_flush,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_signed,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_flush,
    output logic [32:0] mult_a,
    output logic [32:0] mult_b,
    input  logic [65:0] mult_p,
    output logic        rsp0_valid,
    output logic [65:0] rsp0_result,
    output logic        rsp0_overflow,
    output logic        rsp1_valid,
    output logic [65:0] rsp1_result,
    output logic        rsp1_overflow
);

    localparam int DATA_W = 32;
    localparam int EXT_W  = 33;
    localparam int PROD_W = 66;
    localparam int LAST   = LATENCY - 1;

    function automatic logic [EXT_W-1:0] extend_op(input logic [DATA_W-1:0] x,
                                                   input logic [1:0] size,
                                                   input logic sgn);
        logic e;
        logic [EXT_W-1:0] r;
        e = 1'b0;
        r = '0;
        case (size)
            2'd0: begin
                e = sgn & x[7];
                r = {{25{e}}, x[7:0]};
            end
            2'd1: begin
                e = sgn & x[15];
                r = {{17{e}}, x[15:0]};
            end
            default: begin
                e = sgn & x[31];
                r = {e, x};
            end
        endcase
        return r;
    endfunction

    // Product must be a pure sign (or zero) extension of its low w bits.
    function automatic logic overflow_of(input logic [PROD_W-1:0] p,
                                         input logic [1:0] size,
                                         input logic sgn);
        logic s;
        logic o;
        s = 1'b0;
        o = 1'b0;
        case (size)
            2'd0: begin
                s = sgn & p[7];
                o = (p[PROD_W-1:8] != {58{s}});
            end
            2'd1: begin
                s = sgn & p[15];
                o = (p[PROD_W-1:16] != {50{s}});
            end
            default: begin
                s = sgn & p[31];
                o = (p[PROD_W-1:32] != {34{s}});
            end
        endcase
        return o;
    endfunction

    logic             r_rr;
    logic             r_vld_p  [LATENCY];
    logic             r_port_p [LATENCY];
    logic             r_sgn_p  [LATENCY];
    logic [1:0]       r_size_p [LATENCY];

    logic             w_elig0, w_elig1, w_gnt0, w_gnt1;
    logic             w_kill   [LATENCY];
    logic             w_iss_sgn;
    logic [1:0]       w_iss_size;

    // Reset also masks grants so nothing issues while the pipeline is held clear.
    assign w_elig0 = req0_valid & ~req0_flush & ~rst;
    assign w_elig1 = req1_valid & ~req1_flush & ~rst;
    assign w_gnt0  = w_elig0 & (~w_elig1 | ~r_rr);
    assign w_gnt1  = w_elig1 & (~w_elig0 |  r_rr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        mult_a     = '0;
        mult_b     = '0;
        w_iss_sgn  = 1'b0;
        w_iss_size = 2'd0;
        if (w_gnt0) begin
            mult_a     = extend_op(req0_a, req0_size, req0_signed);
            mult_b     = extend_op(req0_b, req0_size, req0_signed);
            w_iss_sgn  = req0_signed;
            w_iss_size = req0_size;
        end else if (w_gnt1) begin
            mult_a     = extend_op(req1_a, req1_size, req1_signed);
            mult_b     = extend_op(req1_b, req1_size, req1_signed);
            w_iss_sgn  = req1_signed;
            w_iss_size = req1_size;
        end
    end

    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            w_kill[i] = r_port_p[i] ? req1_flush : req0_flush;
        end
    end

    // Stage 0 boundary: issue; later stages shift with flush applied in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= RR_RESET_PRIO;
            for (int i = 0; i < LATENCY; i++) begin
                r_vld_p[i] <= 1'b0;
            end
        end else begin
            if (w_gnt0) begin
                r_rr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr <= 1'b0;
            end
            r_vld_p[0] <= w_gnt0 | w_gnt1;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1] & ~w_kill[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_port_p[0] <= w_gnt1;
        r_sgn_p[0]  <= w_iss_sgn;
        r_size_p[0] <= w_iss_size;
        for (int i = 1; i < LATENCY; i++) begin
            r_port_p[i] <= r_port_p[i-1];
            r_sgn_p[i]  <= r_sgn_p[i-1];
            r_size_p[i] <= r_size_p[i-1];
        end
    end

    // Output boundary: last tag stage qualifies the multiplier product.
    logic w_ovf;
    assign w_ovf = overflow_of(mult_p, r_size_p[LAST], r_sgn_p[LAST]);

    assign rsp0_valid    = r_vld_p[LAST] & ~r_port_p[LAST] & ~req0_flush;
    assign rsp1_valid    = r_vld_p[LAST] &  r_port_p[LAST] & ~req1_flush;
    assign rsp0_result   = mult_p;
    assign rsp1_result   = mult_p;
    assign rsp0_overflow = rsp0_valid & w_ovf;
    assign rsp1_overflow = rsp1_valid & w_ovf;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a queue scoreboard checked by a negedge monitor.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_signed, req0_flush;
    logic [1:0]  req0_size;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_signed, req1_flush;
    logic [1:0]  req1_size;
    logic [31:0] req1_a, req1_b;
    logic [32:0] mult_a, mult_b;
    logic [65:0] mult_p;
    logic        rsp0_valid, rsp0_overflow, rsp1_valid, rsp1_overflow;
    logic [65:0] rsp0_result, rsp1_result;

    always #5 clk = ~clk;

    mult_share_arbiter #(.LATENCY(2), .RR_RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
        .req0_size(req0_size), .req0_a(req0_a), .req0_b(req0_b), .req0_flush(req0_flush),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
        .req1_size(req1_size), .req1_a(req1_a), .req1_b(req1_b), .req1_flush(req1_flush),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_overflow(rsp0_overflow),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_overflow(rsp1_overflow)
    );

    // Two-stage signed multiplier standing in for simple_mult.
    logic [65:0] p_s1, p_s2;
    always @(posedge clk) begin
        p_s1 <= $signed(mult_a) * $signed(mult_b);
        p_s2 <= p_s1;
    end
    assign mult_p = p_s2;

    typedef struct packed {
        logic        port;
        logic [65:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic port, input logic [65:0] res, input logic ovf);
        exp_t e;
        e.port = port;
        e.res  = res;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
            if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 66'd1, 66'd0);
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {64'd0, rsp1_valid, rsp0_valid}, 66'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_port", {65'd0, rsp1_valid}, {65'd0, mon_e.port});
                chk("rsp_result", rsp1_valid ? rsp1_result : rsp0_result, mon_e.res);
                chk("rsp_overflow", {65'd0, rsp1_valid ? rsp1_overflow : rsp0_overflow},
                    {65'd0, mon_e.ovf});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req0_valid = 0; req0_signed = 0; req0_size = 0; req0_a = 0; req0_b = 0; req0_flush = 0;
        req1_valid = 0; req1_signed = 0; req1_size = 0; req1_a = 0; req1_b = 0; req1_flush = 0;
    endtask

    task automatic set0(input logic v, input logic s, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_signed = s; req0_size = sz; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic s, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_signed = s; req1_size = sz; req1_a = a; req1_b = b;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp0_valid", {65'd0, rsp0_valid}, 66'd0);
        chk("reset_rsp1_valid", {65'd0, rsp1_valid}, 66'd0);
        chk("reset_ready0", {65'd0, req0_ready}, 66'd0);
        chk("reset_mult_a", {33'd0, mult_a}, 66'd0);
        rst = 1'b0;
        tick();

        // Signed byte 0xFF * 2 = -2
        set0(1, 1, 2'd0, 32'h0000_00FF, 32'h0000_0002);
        #1;
        chk("t1_ready0", {65'd0, req0_ready}, 66'd1);
        chk("t1_ready1", {65'd0, req1_ready}, 66'd0);
        chk("t1_mult_a", {33'd0, mult_a}, {33'd0, 33'h1_FFFF_FFFF});
        chk("t1_mult_b", {33'd0, mult_b}, 66'd2);
        push(1'b0, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b0);
        tick();

        // Unsigned half 0x8000 * 2 = 0x10000, overflows 16 bits
        set0(1, 0, 2'd1, 32'h0000_8000, 32'h0000_0002);
        #1;
        chk("t2_ready0", {65'd0, req0_ready}, 66'd1);
        chk("t2_mult_a", {33'd0, mult_a}, 66'h0_8000);
        push(1'b0, 66'h1_0000, 1'b1);
        tick();
        clr();
        #1;
        chk("idle_mult_a", {33'd0, mult_a}, 66'd0);
        chk("idle_ready0", {65'd0, req0_ready}, 66'd0);
        repeat (3) tick();

        // Round robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1, 1, 2'd1, 32'h0000_FFFF, 32'h0000_0003);
        set1(1, 0, 2'd0, 32'h0000_0010, 32'h0000_0010);
        #1;
        chk("t3_c1_ready0", {65'd0, req0_ready}, 66'd1);
        chk("t3_c1_ready1", {65'd0, req1_ready}, 66'd0);
        push(1'b0, 66'h3_FFFF_FFFF_FFFF_FFFD, 1'b0);
        tick();
        set0(1, 0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        chk("t3_c2_ready1", {65'd0, req1_ready}, 66'd1);
        chk("t3_c2_ready0", {65'd0, req0_ready}, 66'd0);
        push(1'b1, 66'h100, 1'b1);
        tick();
        set1(1, 1, 2'd0, 32'h0000_0005, 32'h0000_00FD);
        #1;
        chk("t3_c3_ready0", {65'd0, req0_ready}, 66'd1);
        chk("t3_c3_ready1", {65'd0, req1_ready}, 66'd0);
        push(1'b0, 66'h0_FFFF_FFFE_0000_0001, 1'b1);
        tick();
        #1;
        chk("t3_c4_ready1", {65'd0, req1_ready}, 66'd1);
        chk("t3_c4_ready0", {65'd0, req0_ready}, 66'd0);
        push(1'b1, 66'h3_FFFF_FFFF_FFFF_FFF1, 1'b0);
        tick();
        clr();
        repeat (4) tick();

        // Flush port 0 while its op is in flight; port 1 unaffected
        set0(1, 0, 2'd0, 32'h3, 32'h4);
        #1;
        chk("t4_issue_ready0", {65'd0, req0_ready}, 66'd1);
        tick();
        req0_flush = 1'b1;
        set1(1, 0, 2'd1, 32'h0000_0100, 32'h0000_0100);
        #1;
        chk("t4_flush_ready0", {65'd0, req0_ready}, 66'd0);
        chk("t4_flush_ready1", {65'd0, req1_ready}, 66'd1);
        push(1'b1, 66'h1_0000, 1'b1);
        tick();
        clr();
        repeat (4) tick();

        // Back-to-back port 1 issues
        for (int i = 0; i < 5; i++) begin
            set1(1, 1, 2'd2, 32'h8000_0000, 32'h0000_0002);
            #1;
            chk("t5_ready1", {65'd0, req1_ready}, 66'd1);
            if (i == 0) chk("t5_mult_a", {33'd0, mult_a}, {33'd0, 33'h1_8000_0000});
            push(1'b1, 66'h3_FFFF_FFFF_0000_0000, 1'b1);
            tick();
        end
        clr();
        repeat (4) tick();

        // Reset while an op is in flight
        set0(1, 0, 2'd0, 32'h1, 32'h1);
        #1;
        chk("t6_issue_ready0", {65'd0, req0_ready}, 66'd1);
        tick();
        rst = 1'b1;
        set0(1, 0, 2'd0, 32'h7, 32'h6);
        set1(1, 0, 2'd0, 32'h2, 32'h2);
        #1;
        chk("t6_rst_ready0", {65'd0, req0_ready}, 66'd0);
        chk("t6_rst_ready1", {65'd0, req1_ready}, 66'd0);
        chk("t6_rst_mult_a", {33'd0, mult_a}, 66'd0);
        tick();
        chk("t6_rst_rsp0", {65'd0, rsp0_valid}, 66'd0);
        chk("t6_rst_rsp1", {65'd0, rsp1_valid}, 66'd0);
        rst = 1'b0;
        #1;
        chk("t6_rr_ready0", {65'd0, req0_ready}, 66'd1);
        chk("t6_rr_ready1", {65'd0, req1_ready}, 66'd0);
        push(1'b0, 66'h2A, 1'b0);
        tick();
        clr();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 66'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
